// File: rtl/writeback_stage.sv
// writeback_stage: commits ALU results to the register file, flags, IN/OUT ports and HALT latch
module writeback_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              isValid,
    input  logic [REG_AW-1:0] Rd,
    input  logic [DATA_W-1:0] Out,
    input  logic              S,
    input  logic              Z,
    input  logic              C,
    input  logic              V,
    input  logic              iRdWriteFlag,
    input  logic              SZCVWriteFlag,
    input  logic              inputFlag,
    input  logic              outputFlag,
    input  logic              HaltFlag,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [3:0]        szcv,
    output logic              stall,
    output logic              halted
);
    localparam int NREG = 2 ** REG_AW;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [DATA_W-1:0] out_data_q, out_data_d, wval;
    logic [3:0]        szcv_q, szcv_d;
    logic              out_valid_q, out_valid_d, halted_q, halted_d;
    logic              accept, rf_we, out_load;
    always_comb begin
        stall = reset | halted_q | (isValid & inputFlag & !in_valid)
              | (isValid & outputFlag & out_valid_q & !out_ready);
        accept = isValid & !stall;
        in_ready = accept & inputFlag;
        wval = inputFlag ? in_data : Out;
        rf_we = accept & iRdWriteFlag;
        out_load = accept & outputFlag;
        ra_data = (rf_we && Rd == ra_addr) ? wval : regs_q[ra_addr];
        rb_data = (rf_we && Rd == rb_addr) ? wval : regs_q[rb_addr];
        szcv_d = !(accept & SZCVWriteFlag) ? szcv_q :
                 inputFlag ? {in_data[DATA_W-1], in_data == '0, 2'b00} : {S, Z, C, V};
        // a drain and a new OUT in the same cycle leave the buffer full
        out_valid_d = out_load | (out_valid_q & !out_ready);
        out_data_d = out_load ? st_data : out_data_q;
        halted_d = halted_q | (accept & HaltFlag);
        for (int i = 0; i < NREG; i++)
            regs_d[i] = (rf_we && Rd == REG_AW'(i)) ? wval : regs_q[i];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            szcv_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            halted_q    <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            szcv_q      <= szcv_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            halted_q    <= halted_d;
        end
    end
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign szcv      = szcv_q;
    assign halted    = halted_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors with a per-cycle reference model and literal spot checks
module tb_writeback_stage;
    logic        clock = 0, reset = 1;
    logic        isValid = 0, S = 0, Z = 0, C = 0, V = 0;
    logic        iRdWriteFlag = 0, SZCVWriteFlag = 0, inputFlag = 0, outputFlag = 0, HaltFlag = 0;
    logic [2:0]  Rd = 0, ra_addr = 0, rb_addr = 0;
    logic [15:0] Out = 0, st_data = 0, in_data = 0;
    logic        in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, stall, halted;
    logic [15:0] out_data, ra_data, rb_data;
    logic [3:0]  szcv;
    int n_tests = 0, n_fail = 0;
    bit chk_en = 0;

    writeback_stage dut (
        .clock(clock), .reset(reset), .isValid(isValid), .Rd(Rd), .Out(Out),
        .S(S), .Z(Z), .C(C), .V(V),
        .iRdWriteFlag(iRdWriteFlag), .SZCVWriteFlag(SZCVWriteFlag),
        .inputFlag(inputFlag), .outputFlag(outputFlag), .HaltFlag(HaltFlag),
        .st_data(st_data), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
        .szcv(szcv), .stall(stall), .halted(halted)
    );

    always #5 clock = ~clock;

    // reference state
    logic [15:0] m_regs [8];
    logic [3:0]  m_szcv = 0;
    logic        m_ov = 0, m_halt = 0;
    logic [15:0] m_od = 0;

    function automatic bit e_stall();
        if (reset || m_halt) return 1;
        if (isValid && inputFlag && !in_valid) return 1;
        if (isValid && outputFlag && m_ov && !out_ready) return 1;
        return 0;
    endfunction

    function automatic bit e_take();
        return isValid && !e_stall();
    endfunction

    function automatic logic [15:0] e_val();
        return inputFlag ? in_data : Out;
    endfunction

    function automatic logic [15:0] e_read(input logic [2:0] a);
        if (e_take() && iRdWriteFlag && Rd == a) return e_val();
        return m_regs[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0;
            m_szcv <= 0; m_ov <= 0; m_od <= 0; m_halt <= 0;
        end else begin
            if (e_take() && iRdWriteFlag) m_regs[Rd] <= e_val();
            if (e_take() && SZCVWriteFlag)
                m_szcv <= inputFlag ? {in_data[15], in_data == 16'h0, 2'b00} : {S, Z, C, V};
            if (m_ov && out_ready) m_ov <= 0;
            if (e_take() && outputFlag) begin m_ov <= 1; m_od <= st_data; end
            if (e_take() && HaltFlag) m_halt <= 1;
        end
    end

    always @(negedge clock) if (chk_en) begin
        chk("stall", stall, e_stall());
        chk("in_ready", in_ready, e_take() && inputFlag);
        chk("ra_data", ra_data, e_read(ra_addr));
        chk("rb_data", rb_data, e_read(rb_addr));
        chk("szcv", szcv, m_szcv);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("halted", halted, m_halt);
    end

    task automatic cyc();
        @(posedge clock); #1;
    endtask

    task automatic idle();
        isValid = 0; iRdWriteFlag = 0; SZCVWriteFlag = 0; inputFlag = 0;
        outputFlag = 0; HaltFlag = 0; S = 0; Z = 0; C = 0; V = 0;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        cyc(); cyc();
        chk_en = 1;
        settle();
        chk("lit reset stall", stall, 1);
        chk("lit reset in_ready", in_ready, 0);
        reset = 0; cyc(); settle();
        chk("lit post-reset stall", stall, 0);
        chk("lit post-reset szcv", szcv, 4'b0000);
        chk("lit post-reset out_valid", out_valid, 0);
        // add commit with same-cycle bypass
        isValid = 1; Rd = 3; Out = 16'h1234; iRdWriteFlag = 1; SZCVWriteFlag = 1; ra_addr = 3;
        settle();
        chk("lit add bypass", ra_data, 16'h1234);
        cyc(); idle(); rb_addr = 3; settle();
        chk("lit add reg3", rb_data, 16'h1234);
        chk("lit add szcv", szcv, 4'b0000);
        // compare: flags only
        isValid = 1; SZCVWriteFlag = 1; Z = 1; Rd = 3; Out = 16'hFFFF;
        cyc(); idle(); settle();
        chk("lit cmp reg3", ra_data, 16'h1234);
        chk("lit cmp szcv", szcv, 4'b0100);
        // r5 <= BEEF with S,C,V so the later IN visibly changes flags
        isValid = 1; Rd = 5; Out = 16'hBEEF; iRdWriteFlag = 1; SZCVWriteFlag = 1; S = 1; C = 1; V = 1;
        cyc(); idle(); ra_addr = 5; settle();
        chk("lit r5", ra_data, 16'hBEEF);
        chk("lit szcv 1011", szcv, 4'b1011);
        // IN stall then completion with zero
        isValid = 1; inputFlag = 1; iRdWriteFlag = 1; SZCVWriteFlag = 1; Rd = 5; Out = 16'h7777;
        in_valid = 0; in_data = 16'h0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("lit in stall", stall, 1);
            chk("lit in not ready", in_ready, 0);
            cyc();
        end
        in_valid = 1; settle();
        chk("lit in ready", in_ready, 1);
        chk("lit in bypass", ra_data, 16'h0000);
        cyc(); idle(); in_valid = 0; settle();
        chk("lit in reg5", ra_data, 16'h0000);
        chk("lit in szcv", szcv, 4'b0100);
        // IN of a negative value into r6
        isValid = 1; inputFlag = 1; iRdWriteFlag = 1; SZCVWriteFlag = 1; Rd = 6;
        in_valid = 1; in_data = 16'h8001; ra_addr = 6;
        cyc(); idle(); in_valid = 0; settle();
        chk("lit in neg reg6", ra_data, 16'h8001);
        chk("lit in neg szcv", szcv, 4'b1000);
        // OUT back-pressure
        isValid = 1; outputFlag = 1; st_data = 16'hAAAA; out_ready = 0;
        settle();
        chk("lit out1 no stall", stall, 0);
        cyc(); st_data = 16'h5555; settle();
        chk("lit out1 valid", out_valid, 1);
        chk("lit out1 data", out_data, 16'hAAAA);
        chk("lit out2 stall", stall, 1);
        cyc(); cyc(); settle();
        chk("lit out2 still stall", stall, 1);
        chk("lit out data held", out_data, 16'hAAAA);
        out_ready = 1; settle();
        chk("lit out2 released", stall, 0);
        cyc(); idle(); out_ready = 0; settle();
        chk("lit out2 valid", out_valid, 1);
        chk("lit out2 data", out_data, 16'h5555);
        // throughput: one word per cycle with out_ready high
        out_ready = 1; isValid = 1; outputFlag = 1;
        for (int i = 1; i <= 4; i++) begin st_data = 16'(i); cyc(); end
        idle(); cyc(); settle();
        chk("lit drained", out_valid, 0);
        // HALT with a pending output, then reset mid-operation
        out_ready = 0; isValid = 1; outputFlag = 1; st_data = 16'hCAFE;
        cyc(); idle(); isValid = 1; HaltFlag = 1;
        cyc(); idle(); settle();
        chk("lit halted", halted, 1);
        chk("lit halt stall", stall, 1);
        isValid = 1; iRdWriteFlag = 1; Rd = 2; Out = 16'hDEAD; ra_addr = 2;
        settle();
        chk("lit halt no bypass", ra_data, 16'h0000);
        cyc(); settle();
        chk("lit halt no write", ra_data, 16'h0000);
        chk("lit halt pending", out_valid, 1);
        reset = 1; cyc(); reset = 0; idle(); settle();
        chk("lit rst out_valid", out_valid, 0);
        chk("lit rst halted", halted, 0);
        chk("lit rst szcv", szcv, 4'b0000);
        chk("lit rst stall", stall, 0);
        for (int i = 0; i < 8; i++) begin
            ra_addr = 3'(i); settle();
            chk("lit rst reg", ra_data, 16'h0000);
            #1;
        end
        // HALT: pending output still drains
        isValid = 1; outputFlag = 1; st_data = 16'hCAFE;
        cyc(); idle(); isValid = 1; HaltFlag = 1;
        cyc(); idle(); settle();
        chk("lit halt2 pending", out_valid, 1);
        chk("lit halt2 data", out_data, 16'hCAFE);
        out_ready = 1; cyc(); settle();
        chk("lit halt2 drained", out_valid, 0);
        chk("lit halt2 still halted", halted, 1);
        cyc();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
